inc_dec_counter: RTL and testbench
==================================

Name: inc_dec_counter

Overview:
Registered, parametrised up/down counter built on the team's increment/decrement datapath. It generalises the combinational +/-1 unit to a programmable step, a programmable [Min, Max] range, a wrap or saturate mode, synchronous load, and boundary/overflow flags. It serves as a general-purpose address, credit or timer counter in the datapath.

Parameters:
WIDTH, 8, counter bit width (>= 2)
STEP_W, 4, step input width (1 <= STEP_W <= WIDTH)
RESET_VAL, 0, value of Q on reset (WIDTH bits)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
En  input  1  count enable
DecEn  input  1  0 = count up, 1 = count down
Load  input  1  synchronous load of LoadVal
LoadVal  input  WIDTH  load value
Step  input  STEP_W  unsigned step magnitude
Mode  input  1  0 = wrap, 1 = saturate
Min  input  WIDTH  lower range bound (inclusive)
Max  input  WIDTH  upper range bound (inclusive)
Q  output  WIDTH  counter value (registered)
AtMin  output  1  Q == Min (combinational from Q)
AtMax  output  1  Q == Max (combinational from Q)
Ovf  output  1  one-cycle pulse: up step exceeded Max
Unf  output  1  one-cycle pulse: down step went below Min

Behaviour:
- Reset: RST high forces Q=RESET_VAL, Ovf=0, Unf=0 immediately, regardless of CLK. Release is synchronous to the next CLK edge.
- Priority per edge: Load > En > hold.
- Load=1: Q<=LoadVal verbatim, with no clamping to [Min, Max]. Ovf=Unf=0.
- En=1, Load=0: compute in WIDTH+1 bits with Step zero-extended.
  - Up: sum=Q+Step. If sum>Max: wrap gives Q<=Min, saturate gives Q<=Max, and Ovf<=1 in both modes. Otherwise Q<=sum.
  - Down: diff=Q-Step, signed compare. If diff<Min: wrap gives Q<=Max, saturate gives Q<=Min, and Unf<=1. Otherwise Q<=diff.
- Wrap is a reload to the opposite bound. No residual carry-over into the range.
- Q already outside range (after load or a Min/Max change): up from Q>Max counts as overflow; down from Q<Min counts as underflow. Same rules as above.
- Step=0 with En=1: Q holds, no pulse.
- Saturated at a bound: every further step toward that bound re-asserts Ovf/Unf while Q holds.
- Min>Max is an illegal configuration: En is ignored, Q holds, Ovf=Unf=0. Load still works.
- Ovf/Unf are registered. They are high exactly in the cycle where the new Q is visible, and low otherwise, including when En=0.
- Latency: one cycle from sampled inputs to Q/flags. AtMin/AtMax follow Q combinationally.
- Min, Max, Mode, Step and DecEn are sampled only at the active edge. They may change every cycle.

Decomposition:
- Shared package: mode encodings MODE_WRAP=1'b0 and MODE_SAT=1'b1.
- One sub-module, inc_dec_step: a combinational WIDTH+1-bit add/subtract of a zero-extended step. It reuses the existing FA full-adder ripple style and outputs the result plus range-compare bits.
- The top level holds the register, the priority mux and the flag registers.

Test Plan (WIDTH=8, STEP_W=4):
1. Q=0x37 mid-count, RST pulsed between edges -> Q=0x00 immediately, Ovf=Unf=0. Counting resumes on the first edge after RST falls.
2. Mode=0, Min=0x10, Max=0x20, Q=0x1E, Step=3, up -> Q=0x10 with Ovf=1 for one cycle. Next up step gives Q=0x13, Ovf=0.
3. Mode=1, Min=0x05, Q=0x07, Step=4, down for two cycles -> Q=0x05 with Unf=1 on both cycles, and AtMin=1.
4. Load=1 and En=1 together, LoadVal=0xAA, Max=0x20 -> Q=0xAA, no pulse. Next up step with Step=1 gives wrap to Min and Ovf=1.
5. Min=0x00, Max=0xFF, Q=0xFF, Step=1, up, wrap -> Q=0x00, Ovf=1. This checks the carry beyond WIDTH bits.
6. Min=0x30, Max=0x20, En=1 for 3 cycles -> Q unchanged, Ovf=Unf=0. Then Step=0 with a legal range -> Q unchanged, no pulse.

Source files
------------

// File: rtl/inc_dec_counter_pkg.sv
// Shared encodings for the inc/dec counter family.
package inc_dec_counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/inc_dec_counter_step.sv
// Combinational WIDTH+1-bit ripple add/subtract of a zero-extended step,
// with the range-compare bits the counter needs to decide wrap/saturate.
module inc_dec_step #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_sub,
  input  logic [WIDTH-1:0]  i_min,
  input  logic [WIDTH-1:0]  i_max,
  output logic [WIDTH-1:0]  o_res,
  output logic              o_above,
  output logic              o_below
);
  logic        [WIDTH:0] w_a;
  logic        [WIDTH:0] w_b;
  logic        [WIDTH:0] w_bx;
  logic        [WIDTH:0] w_c;
  logic signed [WIDTH:0] w_res;
  logic signed [WIDTH:0] w_min_s;
  logic        [WIDTH:0] w_max_u;

  assign w_a     = {1'b0, i_a};
  assign w_b     = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  assign w_bx    = i_sub ? ~w_b : w_b;
  assign w_c[0]  = i_sub;
  assign w_min_s = {1'b0, i_min};
  assign w_max_u = {1'b0, i_max};

  // Ripple of full-adder cells; subtraction is a + ~b + 1 via the carry-in.
  for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
    assign w_res[g] = w_a[g] ^ w_bx[g] ^ w_c[g];
    if (g < WIDTH) begin : g_carry
      assign w_c[g+1] = (w_a[g] & w_bx[g]) | (w_c[g] & (w_a[g] ^ w_bx[g]));
    end
  end

  assign o_res   = w_res[WIDTH-1:0];
  assign o_above = !i_sub && ($unsigned(w_res) > w_max_u);
  assign o_below = i_sub && (w_res < w_min_s);
endmodule

// File: rtl/inc_dec_counter.sv
// Registered up/down counter with programmable step, [Min, Max] range,
// wrap/saturate mode, synchronous load and overflow/underflow pulses.
module inc_dec_counter
  import inc_dec_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              En,
  input  logic              DecEn,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  input  logic [STEP_W-1:0] Step,
  input  logic              Mode,
  input  logic [WIDTH-1:0]  Min,
  input  logic [WIDTH-1:0]  Max,
  output logic [WIDTH-1:0]  Q,
  output logic              AtMin,
  output logic              AtMax,
  output logic              Ovf,
  output logic              Unf
);
  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_res;
  logic             w_above;
  logic             w_below;
  logic             w_illegal;

  // Bound to land on when a step leaves the range: wrap reloads the
  // opposite bound, saturate clamps to the bound being crossed.
  function automatic logic [WIDTH-1:0] exit_bound(input logic mode, input logic up,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] hi);
    return ((mode == MODE_SAT) == up) ? hi : lo;
  endfunction

  inc_dec_step #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_step (
    .i_a     (r_q),
    .i_step  (Step),
    .i_sub   (DecEn),
    .i_min   (Min),
    .i_max   (Max),
    .o_res   (w_res),
    .o_above (w_above),
    .o_below (w_below)
  );

  assign w_illegal = Min > Max;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q   <= RESET_VAL;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (Load) begin
        r_q <= LoadVal;
      end else if (En && !w_illegal && (Step != '0)) begin
        if (w_above) begin
          r_q   <= exit_bound(Mode, 1'b1, Min, Max);
          r_ovf <= 1'b1;
        end else if (w_below) begin
          r_q   <= exit_bound(Mode, 1'b0, Min, Max);
          r_unf <= 1'b1;
        end else begin
          r_q <= w_res;
        end
      end
    end
  end

  assign Q     = r_q;
  assign Ovf   = r_ovf;
  assign Unf   = r_unf;
  assign AtMin = (r_q == Min);
  assign AtMax = (r_q == Max);
endmodule

// File: tb/tb_inc_dec_counter.sv
// Self-checking bench for inc_dec_counter: integer reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_inc_dec_counter;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          En = 1'b0, DecEn = 1'b0, Load = 1'b0, Mode = 1'b0;
  logic [W-1:0]  LoadVal = '0, Min = '0, Max = 8'hFF;
  logic [SW-1:0] Step = 4'd1;
  logic [W-1:0]  Q;
  logic          AtMin, AtMax, Ovf, Unf;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference state, computed with plain integer arithmetic.
  int m_q = 0, m_ovf = 0, m_unf = 0;
  int s_val;

  inc_dec_counter #(.WIDTH(W), .STEP_W(SW), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .En(En), .DecEn(DecEn), .Load(Load),
    .LoadVal(LoadVal), .Step(Step), .Mode(Mode), .Min(Min), .Max(Max),
    .Q(Q), .AtMin(AtMin), .AtMax(AtMax), .Ovf(Ovf), .Unf(Unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = 0; m_unf = 0;
      if (Load) begin
        m_q = int'(LoadVal);
      end else if (En && (int'(Min) <= int'(Max)) && (Step != 0)) begin
        if (!DecEn) begin
          s_val = m_q + int'(Step);
          if (s_val > int'(Max)) begin
            m_q = Mode ? int'(Max) : int'(Min);
            m_ovf = 1;
          end else m_q = s_val;
        end else begin
          s_val = m_q - int'(Step);
          if (s_val < int'(Min)) begin
            m_q = Mode ? int'(Min) : int'(Max);
            m_unf = 1;
          end else m_q = s_val;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on && !RST) begin
      chk("model_q", int'(Q), m_q);
      chk("model_ovf", int'(Ovf), m_ovf);
      chk("model_unf", int'(Unf), m_unf);
      chk("model_atmin", int'(AtMin), int'(m_q == int'(Min)));
      chk("model_atmax", int'(AtMax), int'(m_q == int'(Max)));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    Load = 1'b1; LoadVal = v; En = 1'b0;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_q", int'(Q), 0);
    chk("reset_flags", int'({Ovf, Unf}), 0);
    chk("reset_atmin", int'(AtMin), 1);
    RST = 1'b0;
    chk_on = 1'b1;

    // 1: asynchronous reset mid-count
    load(8'h37);
    chk("t1_load", int'(Q), 8'h37);
    En = 1'b1; Step = 4'd1; DecEn = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("t1_async_q", int'(Q), 0);
    chk("t1_async_flags", int'({Ovf, Unf}), 0);
    #1 RST = 1'b0;
    tick();
    chk("t1_resume", int'(Q), 8'h01);

    // 2: wrap overflow, then normal step
    Mode = 1'b0; Min = 8'h10; Max = 8'h20;
    load(8'h1E);
    En = 1'b1; Step = 4'd3; DecEn = 1'b0;
    tick();
    chk("t2_wrap_q", int'(Q), 8'h10);
    chk("t2_wrap_ovf", int'(Ovf), 1);
    tick();
    chk("t2_next_q", int'(Q), 8'h13);
    chk("t2_next_ovf", int'(Ovf), 0);
    En = 1'b0;
    tick();
    chk("t2_idle_q", int'(Q), 8'h13);

    // 3: saturating underflow held at Min
    Mode = 1'b1; Min = 8'h05; Max = 8'h20;
    load(8'h07);
    En = 1'b1; Step = 4'd4; DecEn = 1'b1;
    tick();
    chk("t3_sat1_q", int'(Q), 8'h05);
    chk("t3_sat1_unf", int'(Unf), 1);
    tick();
    chk("t3_sat2_q", int'(Q), 8'h05);
    chk("t3_sat2_unf", int'(Unf), 1);
    chk("t3_atmin", int'(AtMin), 1);

    // saturating overflow re-asserts at Max
    Min = 8'h00; Max = 8'h20;
    load(8'h1E);
    En = 1'b1; Step = 4'd3; DecEn = 1'b0;
    tick();
    chk("sat_up1_q", int'(Q), 8'h20);
    chk("sat_up1_ovf", int'(Ovf), 1);
    tick();
    chk("sat_up2_ovf", int'(Ovf), 1);
    chk("sat_up2_atmax", int'(AtMax), 1);

    // 4: Load wins over En, out-of-range value kept verbatim
    Mode = 1'b0; Min = 8'h10; Max = 8'h20;
    Load = 1'b1; LoadVal = 8'hAA; En = 1'b1; Step = 4'd1; DecEn = 1'b0;
    tick();
    Load = 1'b0;
    chk("t4_load_q", int'(Q), 8'hAA);
    chk("t4_load_ovf", int'(Ovf), 0);
    tick();
    chk("t4_wrap_q", int'(Q), 8'h10);
    chk("t4_wrap_ovf", int'(Ovf), 1);

    // down from below Min wraps to Max
    load(8'h02);
    En = 1'b1; DecEn = 1'b1; Step = 4'd1;
    tick();
    chk("below_wrap_q", int'(Q), 8'h20);
    chk("below_wrap_unf", int'(Unf), 1);

    // 5: full range, carry beyond WIDTH bits
    Min = 8'h00; Max = 8'hFF; Mode = 1'b0;
    load(8'hFF);
    En = 1'b1; DecEn = 1'b0; Step = 4'd1;
    tick();
    chk("t5_q", int'(Q), 8'h00);
    chk("t5_ovf", int'(Ovf), 1);
    DecEn = 1'b1; Step = 4'd15;
    tick();
    chk("t5_down_q", int'(Q), 8'hFF);
    chk("t5_down_unf", int'(Unf), 1);

    // 6: illegal range ignores En; Step=0 holds
    load(8'h44);
    Min = 8'h30; Max = 8'h20; En = 1'b1; DecEn = 1'b0; Step = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_illegal_q", int'(Q), 8'h44);
      chk("t6_illegal_flags", int'({Ovf, Unf}), 0);
    end
    Min = 8'h00; Max = 8'hFF; Step = 4'd0;
    tick();
    chk("t6_step0_q", int'(Q), 8'h44);
    chk("t6_step0_flags", int'({Ovf, Unf}), 0);
    Step = 4'd5;
    tick();
    chk("t6_after_q", int'(Q), 8'h49);

    En = 1'b0;
    tick();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
